// File: rtl/slant_rx_deframer.sv
// Receive-side deframer: hunts SOF/SOL headers in 4-lane slant beats, buffers
// YCbCr 4:2:2 payload in a small FIFO and unpacks it onto an AXI4-Stream video master.
module slant_rx_deframer #(
    parameter int PIX_PER_LINE = 640,
    parameter int LINES        = 480,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data0,
    input  logic [7:0]  rx_data1,
    input  logic [7:0]  rx_data2,
    input  logic [7:0]  rx_data3,
    output logic [23:0] m_axis_video_tdata,
    output logic        m_axis_video_tvalid,
    input  logic        m_axis_video_tready,
    output logic        m_axis_video_tuser,
    output logic        m_axis_video_tlast,
    output logic        err_sync,
    output logic        err_ovf,
    output logic [15:0] frame_cnt
);

    localparam int BEATS = PIX_PER_LINE / 2;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW    = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [LW-1:0] LAST_LINE = LW'(LINES - 1);

    typedef enum logic [1:0] {
        ST_HUNT     = 2'd0,
        ST_PAYLOAD  = 2'd1,
        ST_WAIT_SOL = 2'd2
    } state_t;

    // Beat layout {Y0, Cb, Y1, Cr} = lanes 0..3, MSB first.
    logic          in_valid_r;
    logic [31:0]   in_beat_r;
    logic          in_sof_r;
    logic          in_sol_r;

    state_t        state_r, state_s;
    logic [LW-1:0] line_r, line_s;
    logic [BW-1:0] beat_r, beat_s;
    logic          wr_req_s, wr_sof_s, wr_eol_s, err_sync_s, frame_inc_s;

    logic [33:0]   mem_r [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_r, rd_ptr_r;
    logic          empty_s, full_s, pop_s, wr_ok_s, ovf_s, out_ready_s;
    logic [33:0]   head_s;

    logic          phase_r;
    logic [23:0]   tdata_r;
    logic          tvalid_r, tuser_r, tlast_r;
    logic          err_sync_r, err_ovf_r;
    logic [15:0]   frame_cnt_r;

    function automatic logic is_header(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2);
        return (b0 == 8'hFF) && (b1 == 8'h00) && (b2 == 8'h00);
    endfunction

    // Input register with header decode.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_valid_r <= 1'b0;
            in_beat_r  <= 32'h0000_0000;
            in_sof_r   <= 1'b0;
            in_sol_r   <= 1'b0;
        end else begin
            in_valid_r <= rx_valid;
            in_beat_r  <= {rx_data0, rx_data1, rx_data2, rx_data3};
            in_sof_r   <= is_header(rx_data0, rx_data1, rx_data2) && (rx_data3 == 8'hAB);
            in_sol_r   <= is_header(rx_data0, rx_data1, rx_data2) && (rx_data3 == 8'h80);
        end
    end

    // Framing FSM: next state, counters and FIFO write request.
    always_comb begin
        state_s     = state_r;
        line_s      = line_r;
        beat_s      = beat_r;
        wr_req_s    = 1'b0;
        wr_sof_s    = 1'b0;
        wr_eol_s    = 1'b0;
        err_sync_s  = 1'b0;
        frame_inc_s = 1'b0;
        if (in_valid_r) begin
            case (state_r)
                ST_HUNT: begin
                    if (in_sof_r) begin
                        state_s = ST_PAYLOAD;
                        line_s  = {LW{1'b0}};
                        beat_s  = {BW{1'b0}};
                    end else begin
                        state_s = ST_HUNT;
                    end
                end
                ST_PAYLOAD: begin
                    if (in_sof_r) begin
                        err_sync_s = 1'b1;
                        line_s     = {LW{1'b0}};
                        beat_s     = {BW{1'b0}};
                    end else if (in_sol_r) begin
                        err_sync_s = 1'b1;
                        state_s    = ST_HUNT;
                    end else begin
                        wr_req_s = 1'b1;
                        wr_sof_s = (line_r == {LW{1'b0}}) && (beat_r == {BW{1'b0}});
                        if (beat_r == LAST_BEAT) begin
                            wr_eol_s = 1'b1;
                            beat_s   = {BW{1'b0}};
                            if (line_r == LAST_LINE) begin
                                state_s     = ST_HUNT;
                                frame_inc_s = 1'b1;
                            end else begin
                                state_s = ST_WAIT_SOL;
                            end
                        end else begin
                            beat_s = beat_r + BW'(1);
                        end
                    end
                end
                ST_WAIT_SOL: begin
                    if (in_sol_r) begin
                        state_s = ST_PAYLOAD;
                        line_s  = line_r + LW'(1);
                        beat_s  = {BW{1'b0}};
                    end else if (in_sof_r) begin
                        err_sync_s = 1'b1;
                        state_s    = ST_PAYLOAD;
                        line_s     = {LW{1'b0}};
                        beat_s     = {BW{1'b0}};
                    end else begin
                        err_sync_s = 1'b1;
                        state_s    = ST_HUNT;
                    end
                end
                default: state_s = ST_HUNT;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // FSM state, counters and error/frame outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_HUNT;
            line_r      <= {LW{1'b0}};
            beat_r      <= {BW{1'b0}};
            err_sync_r  <= 1'b0;
            err_ovf_r   <= 1'b0;
            frame_cnt_r <= 16'd0;
        end else begin
            state_r     <= state_s;
            line_r      <= line_s;
            beat_r      <= beat_s;
            err_sync_r  <= err_sync_s;
            err_ovf_r   <= ovf_s;
            frame_cnt_r <= frame_cnt_r + (frame_inc_s ? 16'd1 : 16'd0);
        end
    end

    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign empty_s     = (wr_ptr_r == rd_ptr_r);
    assign full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign head_s      = mem_r[rd_ptr_r[AW-1:0]];
    assign out_ready_s = !tvalid_r || m_axis_video_tready;
    assign pop_s       = out_ready_s && !empty_s && phase_r;
    assign wr_ok_s     = wr_req_s && (!full_s || pop_s);
    assign ovf_s       = wr_req_s && full_s && !pop_s;

    // FIFO storage; contents are don't-care while the pointers are equal.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {wr_sof_s, wr_eol_s, in_beat_r};
        end else begin
            mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {(AW + 1){1'b0}};
            rd_ptr_r <= {(AW + 1){1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_r + (wr_ok_s ? (AW + 1)'(1) : (AW + 1)'(0));
            rd_ptr_r <= rd_ptr_r + (pop_s ? (AW + 1)'(1) : (AW + 1)'(0));
        end
    end

    // Unpacker: head entry stays in the FIFO until its second pixel is taken.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_r  <= 1'b0;
            tvalid_r <= 1'b0;
            tdata_r  <= 24'h000000;
            tuser_r  <= 1'b0;
            tlast_r  <= 1'b0;
        end else if (out_ready_s) begin
            if (empty_s) begin
                tvalid_r <= 1'b0;
            end else if (!phase_r) begin
                tvalid_r <= 1'b1;
                tdata_r  <= {head_s[31:24], head_s[23:16], head_s[7:0]};
                tuser_r  <= head_s[33];
                tlast_r  <= 1'b0;
                phase_r  <= 1'b1;
            end else begin
                tvalid_r <= 1'b1;
                tdata_r  <= {head_s[15:8], head_s[23:16], head_s[7:0]};
                tuser_r  <= 1'b0;
                tlast_r  <= head_s[32];
                phase_r  <= 1'b0;
            end
        end else begin
            tvalid_r <= tvalid_r;
        end
    end

    assign m_axis_video_tdata  = tdata_r;
    assign m_axis_video_tvalid = tvalid_r;
    assign m_axis_video_tuser  = tuser_r;
    assign m_axis_video_tlast  = tlast_r;
    assign err_sync            = err_sync_r;
    assign err_ovf             = err_ovf_r;
    assign frame_cnt           = frame_cnt_r;

endmodule

// File: tb/tb_slant_rx_deframer.sv
// Directed bench for slant_rx_deframer with a 4-pixel, 2-line frame and 16-beat FIFO.
module tb_slant_rx_deframer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rx_valid;
    logic [7:0]  rx_data0, rx_data1, rx_data2, rx_data3;
    logic [23:0] tdata;
    logic        tvalid, tready, tuser, tlast, err_sync, err_ovf;
    logic [15:0] frame_cnt;

    int n_vec  = 0;
    int n_err  = 0;
    int n_sync = 0;
    int n_ovf  = 0;
    int rdy_mode = 1;
    logic [25:0] got_q[$];
    logic [25:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [25:0] prev_px = 26'd0;

    always #5 clk = ~clk;

    slant_rx_deframer #(.PIX_PER_LINE(4), .LINES(2), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rstn(rstn), .rx_valid(rx_valid),
        .rx_data0(rx_data0), .rx_data1(rx_data1), .rx_data2(rx_data2), .rx_data3(rx_data3),
        .m_axis_video_tdata(tdata), .m_axis_video_tvalid(tvalid),
        .m_axis_video_tready(tready), .m_axis_video_tuser(tuser),
        .m_axis_video_tlast(tlast), .err_sync(err_sync), .err_ovf(err_ovf),
        .frame_cnt(frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // tready pattern: 0 = held low, 1 = held high, otherwise toggling
    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       tready = 1'b0;
                1:       tready = 1'b1;
                default: tready = ~tready;
            endcase
        end
    end

    // Output collector, pulse counters and stall-stability check
    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (prev_stall) chk("stall hold", {5'd0, tvalid, tuser, tlast, tdata}, {6'd1, prev_px});
                if (tvalid && tready) got_q.push_back({tuser, tlast, tdata});
                if (err_sync) n_sync++;
                if (err_ovf) n_ovf++;
                prev_stall = tvalid && !tready;
                prev_px    = {tuser, tlast, tdata};
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data0 = a; rx_data1 = b; rx_data2 = c; rx_data3 = d;
    endtask

    task automatic sof();
        send(8'hFF, 8'h00, 8'h00, 8'hAB);
    endtask

    task automatic sol();
        send(8'hFF, 8'h00, 8'h00, 8'h80);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic pay(input int n);
        logic [7:0] v;
        v = 8'(n);
        send(8'h10 + v, 8'h80 + v, 8'h40 + v, 8'hC0 + v);
    endtask

    task automatic expb(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] d, input logic s, input logic e);
        exp_q.push_back({s, 1'b0, a, b, d});
        exp_q.push_back({1'b0, e, c, b, d});
    endtask

    task automatic expp(input int n, input logic s, input logic e);
        logic [7:0] v;
        v = 8'(n);
        expb(8'h10 + v, 8'h80 + v, 8'h40 + v, 8'hC0 + v, s, e);
    endtask

    task automatic check_q(input string tag);
        chk({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s px%0d", tag, i), {6'd0, got_q[i]}, {6'd0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
        n_sync = 0;
        n_ovf  = 0;
    endtask

    initial begin
        rx_valid = 1'b0;
        rx_data0 = 8'h00; rx_data1 = 8'h00; rx_data2 = 8'h00; rx_data3 = 8'h00;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #2;
        chk("reset outputs", {3'd0, tvalid, tuser, tlast, err_sync, err_ovf, tdata}, 32'd0);
        chk("reset frame_cnt", {16'd0, frame_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // basic frame
        sof();
        send(8'h10, 8'h80, 8'h20, 8'h90);
        send(8'h30, 8'h81, 8'h40, 8'h91);
        sol();
        send(8'h50, 8'h82, 8'h60, 8'h92);
        send(8'h70, 8'h83, 8'h80, 8'h93);
        idle(20);
        expb(8'h10, 8'h80, 8'h20, 8'h90, 1'b1, 1'b0);
        expb(8'h30, 8'h81, 8'h40, 8'h91, 1'b0, 1'b1);
        expb(8'h50, 8'h82, 8'h60, 8'h92, 1'b0, 1'b0);
        expb(8'h70, 8'h83, 8'h80, 8'h93, 1'b0, 1'b1);
        chk("basic frame_cnt", {16'd0, frame_cnt}, 32'd1);
        chk("basic err_sync", 32'(n_sync), 32'd0);
        chk("basic err_ovf", 32'(n_ovf), 32'd0);
        check_q("basic");

        // backpressure: tready toggling
        rdy_mode = 2;
        sof();
        send(8'h10, 8'h80, 8'h20, 8'h90);
        send(8'h30, 8'h81, 8'h40, 8'h91);
        sol();
        send(8'h50, 8'h82, 8'h60, 8'h92);
        send(8'h70, 8'h83, 8'h80, 8'h93);
        idle(30);
        rdy_mode = 1;
        idle(4);
        expb(8'h10, 8'h80, 8'h20, 8'h90, 1'b1, 1'b0);
        expb(8'h30, 8'h81, 8'h40, 8'h91, 1'b0, 1'b1);
        expb(8'h50, 8'h82, 8'h60, 8'h92, 1'b0, 1'b0);
        expb(8'h70, 8'h83, 8'h80, 8'h93, 1'b0, 1'b1);
        chk("bp frame_cnt", {16'd0, frame_cnt}, 32'd2);
        chk("bp err_ovf", 32'(n_ovf), 32'd0);
        check_q("bp");

        // overflow: 20 payload beats over 5 frames with tready low
        rdy_mode = 0;
        for (int f = 0; f < 5; f++) begin
            sof();
            pay(4 * f);
            pay(4 * f + 1);
            sol();
            pay(4 * f + 2);
            pay(4 * f + 3);
        end
        idle(5);
        chk("ovf pulses", 32'(n_ovf), 32'd4);
        chk("ovf no output", 32'(got_q.size()), 32'd0);
        chk("ovf tvalid held", {31'd0, tvalid}, 32'd1);
        rdy_mode = 1;
        idle(45);
        for (int f = 0; f < 4; f++) begin
            expp(4 * f, 1'b1, 1'b0);
            expp(4 * f + 1, 1'b0, 1'b1);
            expp(4 * f + 2, 1'b0, 1'b0);
            expp(4 * f + 3, 1'b0, 1'b1);
        end
        chk("ovf frame_cnt", {16'd0, frame_cnt}, 32'd7);
        chk("ovf err_sync", 32'(n_sync), 32'd0);
        check_q("ovf");

        // missing SOL: payload arrives in WAIT_SOL, later beats ignored
        sof();
        pay(32);
        pay(33);
        pay(34);
        pay(35);
        sol();
        pay(36);
        idle(15);
        expp(32, 1'b1, 1'b0);
        expp(33, 1'b0, 1'b1);
        chk("nosol err_sync", 32'(n_sync), 32'd1);
        chk("nosol frame_cnt", {16'd0, frame_cnt}, 32'd7);
        check_q("nosol");

        // SOF after one beat of line 0
        sof();
        pay(40);
        sof();
        pay(41);
        pay(42);
        sol();
        pay(43);
        pay(44);
        idle(20);
        expp(40, 1'b1, 1'b0);
        expp(41, 1'b1, 1'b0);
        expp(42, 1'b0, 1'b1);
        expp(43, 1'b0, 1'b0);
        expp(44, 1'b0, 1'b1);
        chk("midsof err_sync", 32'(n_sync), 32'd1);
        chk("midsof frame_cnt", {16'd0, frame_cnt}, 32'd8);
        check_q("midsof");

        // async reset mid-frame
        rdy_mode = 0;
        sof();
        pay(48);
        pay(49);
        idle(4);
        chk("pre-rst tvalid", {31'd0, tvalid}, 32'd1);
        @(posedge clk); #3;
        rstn = 1'b0;
        #1;
        chk("midrst outputs", {3'd0, tvalid, tuser, tlast, err_sync, err_ovf, tdata}, 32'd0);
        chk("midrst frame_cnt", {16'd0, frame_cnt}, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        got_q.delete();
        n_sync = 0;
        n_ovf  = 0;
        rdy_mode = 1;
        sol();
        pay(50);
        idle(10);
        chk("postrst err_sync", 32'(n_sync), 32'd0);
        check_q("postrst");
        sof();
        pay(60);
        pay(61);
        sol();
        pay(62);
        pay(63);
        idle(20);
        expp(60, 1'b1, 1'b0);
        expp(61, 1'b0, 1'b1);
        expp(62, 1'b0, 1'b0);
        expp(63, 1'b0, 1'b1);
        chk("postrst frame_cnt", {16'd0, frame_cnt}, 32'd1);
        check_q("refill");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
